// File: rtl/spin_ctrl.sv
// spin_ctrl: LED ring spinner that lands on an LFSR-sampled target; SPIN_TRAIL_EN adds a comet tail
module spin_ctrl #(
  parameter int LED_W = 4,
  parameter int BASE_DIV = 2500000,
  parameter int DELAY_INC = 500000,
  parameter int MIN_LAPS = 2,
  parameter int DIV_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [LED_W-1:0]      rnd_i,
  output logic                  rng_en_o,
  output logic [(1<<LED_W)-1:0] led_o,
  output logic                  busy_o,
  output logic                  done_o
);
  localparam int N = 1 << LED_W;
  localparam int LAP_W = $clog2(MIN_LAPS + 1);
  typedef enum logic [1:0] {IDLE, SPIN, SLOW, DONE} state_t;
  state_t state, state_nxt;
  logic [LED_W-1:0] pos, pos_nxt, target, target_nxt, pos_inc;
  logic [DIV_W-1:0] presc, presc_nxt, delay, delay_nxt, delay_sat;
  logic [DIV_W:0] delay_sum;
  logic [LAP_W-1:0] laps, laps_nxt;
  logic moving, step;
  assign moving = state == SPIN || state == SLOW;
  assign step = moving && presc == delay - DIV_W'(1);
  assign pos_inc = pos + LED_W'(1);
  assign delay_sum = {1'b0, delay} + (DIV_W+1)'(DELAY_INC);
  assign delay_sat = delay_sum[DIV_W] ? '1 : delay_sum[DIV_W-1:0];
  always_comb begin
    state_nxt = state;
    pos_nxt = pos;
    target_nxt = target;
    presc_nxt = moving ? (step ? '0 : presc + DIV_W'(1)) : presc;
    delay_nxt = delay;
    laps_nxt = laps;
    if (step) pos_nxt = pos_inc;
    if (state == IDLE && start_i) begin
      state_nxt = SPIN;
      target_nxt = rnd_i;
      laps_nxt = '0;
      presc_nxt = '0;
      delay_nxt = DIV_W'(BASE_DIV);
    end
    if (state == SPIN && step && pos_inc == '0) begin
      laps_nxt = laps + LAP_W'(1);
      if (laps + LAP_W'(1) == LAP_W'(MIN_LAPS)) begin
        state_nxt = SLOW;
        delay_nxt = DIV_W'(BASE_DIV) + DIV_W'(DELAY_INC);
      end
    end
    if (state == SLOW && step) begin
      delay_nxt = delay_sat;
      state_nxt = pos_inc == target ? DONE : SLOW;
    end
    if (state == DONE) state_nxt = IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      pos <= '0;
      target <= '0;
      presc <= '0;
      delay <= DIV_W'(BASE_DIV);
      laps <= '0;
    end else begin
      state <= state_nxt;
      pos <= pos_nxt;
      target <= target_nxt;
      presc <= presc_nxt;
      delay <= delay_nxt;
      laps <= laps_nxt;
    end
  end
  assign rng_en_o = state == IDLE;
  assign busy_o = moving;
  assign done_o = state == DONE;
`ifdef SPIN_TRAIL_EN
  assign led_o = (N'(1) << pos) | (moving ? N'(1) << (pos - LED_W'(1)) : '0);
`else
  assign led_o = N'(1) << pos;
`endif
endmodule
